fifo_axi_wr_ctrl: RTL and testbench

FIFO_AXI_WR_CTRL -- requirements
Module: fifo_axi_wr_ctrl

---
 rtl/fifo_axi_wr_ctrl.sv | 140 ++++++++++++++
 tb/tb_fifo_axi_wr_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_axi_wr_ctrl.sv
// fifo_axi_wr_ctrl: drains a synchronous FIFO into AXI write bursts.
// Words are collected into a local burst buffer, then issued as one INCR
// burst (AW, then W beats, then B). Addresses advance per burst and wrap
// back to BASE_ADDR at the end of the configured region.
module fifo_axi_wr_ctrl #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           BURST_LEN  = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           ADDR_SPAN  = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    flush,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic                    busy,
    output logic                    err,
    output logic [15:0]             burst_cnt
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
    localparam int unsigned IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam logic [2:0]  AWSIZE_VAL = 3'($clog2(BYTES));
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT =
        {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(ADDR_SPAN);

    typedef enum logic [2:0] {IDLE, FILL, ADDR, DATA, RESP} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        captured;
    logic [CNT_W-1:0]        beat;
    logic                    in_flight;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   buffer [0:(1<<IDX_W)-1];

    logic                    last_beat;
    logic                    flush_ready;
    logic [ADDR_WIDTH:0]     addr_sum;
    logic [ADDR_WIDTH-1:0]   addr_next;

    assign last_beat   = (beat == captured - CNT_W'(1));
    assign flush_ready = flush && fifo_empty && (captured != '0) && !in_flight;

    // Next burst address, wrapping to the region base when it runs off the end
    always_comb begin
        addr_sum  = {1'b0, addr_q} + (ADDR_WIDTH+1)'(captured) * (ADDR_WIDTH+1)'(BYTES);
        addr_next = (addr_sum >= ADDR_LIMIT) ? BASE_ADDR : addr_sum[ADDR_WIDTH-1:0];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; enable/flush only matter while collecting words
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (enable) state_next = FILL;
            FILL: begin
                if (captured == CNT_W'(BURST_LEN) || flush_ready)
                    state_next = ADDR;
                else if (!enable && !in_flight && captured == '0)
                    state_next = IDLE;
            end
            ADDR: if (awready)              state_next = DATA;
            DATA: if (wready && last_beat)  state_next = RESP;
            RESP: if (bvalid)               state_next = FILL;
            default:                        state_next = IDLE;
        endcase
    end

    // Output decode; address and data come from registers so they hold under stall
    always_comb begin
        fifo_rd_en = (state == FILL) && enable && !fifo_empty &&
                     (((CNT_W+1)'(captured) + (CNT_W+1)'(in_flight)) < (CNT_W+1)'(BURST_LEN));
        awvalid    = (state == ADDR);
        awaddr     = addr_q;
        awlen      = 8'(captured) - 8'd1;
        awsize     = AWSIZE_VAL;
        awburst    = 2'b01;
        wvalid     = (state == DATA);
        wdata      = buffer[beat[IDX_W-1:0]];
        wstrb      = '1;
        wlast      = (state == DATA) && last_beat;
        bready     = (state == RESP);
        busy       = (state != IDLE);
    end

    // Burst bookkeeping: fill count, beat index, address, status counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight <= 1'b0;
            captured  <= '0;
            beat      <= '0;
            addr_q    <= BASE_ADDR;
            err       <= 1'b0;
            burst_cnt <= '0;
        end else begin
            in_flight <= fifo_rd_en;
            if (in_flight)
                captured <= captured + CNT_W'(1);
            if (state == DATA && wready)
                beat <= last_beat ? '0 : beat + CNT_W'(1);
            if (state == RESP && bvalid) begin
                err       <= err | (bresp != 2'b00);
                burst_cnt <= burst_cnt + 16'd1;
                addr_q    <= addr_next;
                captured  <= '0;
            end
        end
    end

    // Buffer write: FIFO data lands one cycle after its read strobe
    always_ff @(posedge clk) begin
        if (in_flight)
            buffer[captured[IDX_W-1:0]] <= fifo_rd_data;
    end

endmodule

// File: tb/tb_fifo_axi_wr_ctrl.sv
// Bench for fifo_axi_wr_ctrl: FIFO and AXI slave models plus AW/W scoreboards.
module tb_fifo_axi_wr_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data = '0;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready = 1'b1;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready = 1'b1;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b1;
    logic        bready;
    logic        busy;
    logic        err;
    logic [15:0] burst_cnt;

    fifo_axi_wr_ctrl #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .BURST_LEN (4),
        .BASE_ADDR (32'h0),
        .ADDR_SPAN (32)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .busy(busy), .err(err), .burst_cnt(burst_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [7:0] len; } aw_exp_t;
    typedef struct { logic [31:0] data; logic last; } w_exp_t;

    logic [31:0] fifo_q [$];
    aw_exp_t     exp_aw [$];
    w_exp_t      exp_w  [$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_bcnt;
    logic        exp_err;
    bit          bp_mode, berr_mode;
    int          aw_stall, stall_total, b_done, w_beat, cur_run, max_run;
    bit          rd_s, aw_stall_prev, w_stall_prev, aw_done;
    logic [31:0] held_awaddr, held_wdata;
    logic [7:0]  held_awlen;
    logic        held_wlast;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: observe at negedge, update models just after posedge
    task automatic tick();
        aw_exp_t a;
        w_exp_t  w;
        @(negedge clk);
        check("burst_cnt", burst_cnt, exp_bcnt);
        check("err", err, exp_err);
        if (fifo_rd_en) check("rd_when_empty", fifo_empty, 1'b0);
        if (awvalid || wvalid || bready) check("rd_outside_fill", fifo_rd_en, 1'b0);
        if (fifo_rd_en) cur_run++;
        else begin
            if (cur_run > max_run) max_run = cur_run;
            cur_run = 0;
        end
        rd_s = fifo_rd_en;
        if (awvalid) begin
            if (aw_stall_prev) begin
                check("awaddr_stable", awaddr, held_awaddr);
                check("awlen_stable", awlen, held_awlen);
            end
            if (awready) begin
                if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
                else begin
                    a = exp_aw.pop_front();
                    check("awaddr", awaddr, a.addr);
                    check("awlen", awlen, a.len);
                    check("awsize", awsize, 3'd2);
                    check("awburst", awburst, 2'b01);
                end
                aw_done = 1; aw_stall_prev = 0; aw_stall = 0;
            end else begin
                aw_stall_prev = 1; held_awaddr = awaddr; held_awlen = awlen;
                aw_stall++; stall_total++;
            end
        end
        if (wvalid) begin
            check("w_before_aw", aw_done, 1'b1);
            if (w_stall_prev) begin
                check("wdata_stable", wdata, held_wdata);
                check("wlast_stable", wlast, held_wlast);
            end
            if (wready) begin
                if (exp_w.size() == 0) check("w_unexpected", 1, 0);
                else begin
                    w = exp_w.pop_front();
                    check("wdata", wdata, w.data);
                    check("wlast", wlast, w.last);
                    check("wstrb", wstrb, 4'hF);
                end
                w_stall_prev = 0;
                w_beat++;
                if (wlast) begin aw_done = 0; w_beat = 0; end
            end else begin
                w_stall_prev = 1; held_wdata = wdata; held_wlast = wlast;
            end
        end
        if (bready && bvalid) begin
            exp_bcnt++;
            if (bresp != 2'b00) exp_err = 1'b1;
            b_done++;
        end
        @(posedge clk);
        #1;
        if (rd_s) fifo_rd_data = (fifo_q.size() > 0) ? fifo_q.pop_front() : 32'hDEAD_BEEF;
        fifo_empty = (fifo_q.size() == 0);
        if (bp_mode) begin
            awready = (aw_stall >= 5);
            wready  = ~wready;
        end else begin
            awready = 1'b1;
            wready  = 1'b1;
        end
        bresp = (berr_mode && b_done == 1) ? 2'b10 : 2'b00;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; flush = 1'b0; bp_mode = 0; berr_mode = 0;
        fifo_q.delete(); exp_aw.delete(); exp_w.delete();
        fifo_empty = 1'b1; fifo_rd_data = '0;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        exp_bcnt = 0; exp_err = 1'b0; aw_stall = 0; stall_total = 0; b_done = 0;
        rd_s = 0; aw_stall_prev = 0; w_stall_prev = 0; aw_done = 0;
        w_beat = 0; cur_run = 0; max_run = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Queue n random words as one burst; the final word carries wlast
    task automatic push_words(input int n);
        w_exp_t      w;
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            d = $urandom;
            fifo_q.push_back(d);
            w.data = d;
            w.last = (i == n - 1);
            exp_w.push_back(w);
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic expect_aw(input logic [31:0] addr, input logic [7:0] len);
        aw_exp_t a;
        a.addr = addr;
        a.len  = len;
        exp_aw.push_back(a);
    endtask

    task automatic wait_bursts(input int target);
        int budget = 300;
        while (exp_bcnt < target && budget > 0) begin
            tick();
            budget--;
        end
        check("bursts_done", exp_bcnt, target);
        tick();
        check("burst_cnt_final", burst_cnt, target);
        check("aw_drained", exp_aw.size(), 0);
        check("w_drained", exp_w.size(), 0);
    endtask

    task automatic go_idle();
        enable = 1'b0;
        flush  = 1'b0;
        repeat (4) tick();
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        int budget;

        // Reset values
        do_reset();
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_wlast", wlast, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rd_en", fifo_rd_en, 1'b0);
        check("rst_awaddr", awaddr, 32'h0);
        check("rst_burst_cnt", burst_cnt, 16'h0);

        // Two full bursts, all ready signals held high
        do_reset();
        push_words(4); push_words(4);
        expect_aw(32'h00, 8'd3); expect_aw(32'h10, 8'd3);
        enable = 1'b1;
        wait_bursts(2);
        check("rd_run_max", max_run, 4);
        go_idle();

        // Partial bursts driven by flush
        do_reset();
        push_words(2);
        expect_aw(32'h00, 8'd1);
        flush = 1'b1; enable = 1'b1;
        wait_bursts(1);
        push_words(1);
        expect_aw(32'h08, 8'd0);
        wait_bursts(2);
        go_idle();

        // Backpressure on AW and W with the FIFO still holding data
        do_reset();
        bp_mode = 1; awready = 1'b0; wready = 1'b0;
        push_words(4); push_words(4);
        expect_aw(32'h00, 8'd3); expect_aw(32'h10, 8'd3);
        enable = 1'b1;
        wait_bursts(2);
        check("aw_stall_cycles", stall_total, 10);
        bp_mode = 0;
        go_idle();

        // Region wrap and sticky error from the second response
        do_reset();
        berr_mode = 1;
        push_words(4); push_words(4); push_words(4);
        expect_aw(32'h00, 8'd3); expect_aw(32'h10, 8'd3); expect_aw(32'h00, 8'd3);
        enable = 1'b1;
        wait_bursts(3);
        check("err_after_bursts", err, 1'b1);
        go_idle();
        check("err_sticky", err, 1'b1);

        // Reset while the second burst is on its second data beat
        do_reset();
        push_words(4); push_words(4);
        expect_aw(32'h00, 8'd3); expect_aw(32'h10, 8'd3);
        enable = 1'b1;
        budget = 200;
        while (!(exp_bcnt == 1 && w_beat == 1) && budget > 0) begin
            tick();
            budget--;
        end
        check("reached_beat2", w_beat, 1);
        check("mid_wvalid", wvalid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_awvalid", awvalid, 1'b0);
        check("mrst_wvalid", wvalid, 1'b0);
        check("mrst_wlast", wlast, 1'b0);
        check("mrst_bready", bready, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_rd_en", fifo_rd_en, 1'b0);
        check("mrst_awaddr", awaddr, 32'h0);
        check("mrst_burst_cnt", burst_cnt, 16'h0);
        do_reset();
        push_words(4);
        expect_aw(32'h00, 8'd3);
        enable = 1'b1;
        wait_bursts(1);
        go_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
